rf_alu_sequencer: RTL and testbench

RF_ALU_SEQUENCER -- requirements
Module: rf_alu_sequencer

---
 rtl/rf_alu_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_rf_alu_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/rf_alu_sequencer.sv
// rf_alu_sequencer: three-state (IDLE -> EXEC -> WB) sequencer that reads two
// operands from an external register file, runs an 8-bit ALU operation and
// writes the result back. One instruction per three cycles.
// Optional feature: define RF_ALU_MUL_EN to make opcode 11 an unsigned
// multiply (low byte written); without it opcode 11 is illegal.
module rf_alu_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  output logic        instr_ready,
  output logic [3:0]  rf_r_address1,
  output logic [3:0]  rf_r_address2,
  input  logic [7:0]  rf_out1,
  input  logic [7:0]  rf_out2,
  output logic [3:0]  rf_w_address,
  output logic [7:0]  rf_data,
  output logic        rf_write_en,
  output logic        done,
  output logic        illegal,
  output logic        flag_z,
  output logic        flag_c,
  output logic        flag_v
);

  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 4;
  localparam int INSTR_W = 16;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_MOV = 4'd8;
  localparam logic [3:0] OP_LDI = 4'd9;
  localparam logic [3:0] OP_CMP = 4'd10;
  localparam logic [3:0] OP_MUL = 4'd11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] res;
    logic              z;
    logic              c;
    logic              v;
    logic              ok;
  } alu_t;

  // Combinational ALU. ok=0 marks an unsupported opcode; its flag fields are
  // then meaningless and the caller keeps the previous flags.
  function automatic alu_t alu_exec(input logic [3:0]        op,
                                    input logic [DATA_W-1:0] a,
                                    input logic [DATA_W-1:0] b,
                                    input logic [DATA_W-1:0] imm);
    alu_t                     r;
    logic [DATA_W:0]          w;
    logic signed [DATA_W-1:0] sa;
    logic signed [DATA_W-1:0] sb;
    logic signed [DATA_W-1:0] sr;
`ifdef RF_ALU_MUL_EN
    logic [2*DATA_W-1:0]      p;
`endif
    r  = '0;
    r.ok = 1'b1;
    w  = '0;
    sa = signed'(a);
    sb = signed'(b);
    sr = '0;
`ifdef RF_ALU_MUL_EN
    p  = '0;
`endif
    case (op)
      OP_ADD: begin
        w     = {1'b0, a} + {1'b0, b};
        r.res = w[DATA_W-1:0];
        r.c   = w[DATA_W];
        sr    = signed'(r.res);
        r.v   = ((sa < 0) == (sb < 0)) && ((sr < 0) != (sa < 0));
      end
      OP_SUB, OP_CMP: begin
        w     = {1'b0, a} - {1'b0, b};
        r.res = w[DATA_W-1:0];
        r.c   = w[DATA_W];
        sr    = signed'(r.res);
        r.v   = ((sa < 0) != (sb < 0)) && ((sr < 0) != (sa < 0));
      end
      OP_AND: r.res = a & b;
      OP_OR:  r.res = a | b;
      OP_XOR: r.res = a ^ b;
      OP_NOT: r.res = ~a;
      OP_SHL: begin
        r.res = {a[DATA_W-2:0], 1'b0};
        r.c   = a[DATA_W-1];
      end
      OP_SHR: begin
        r.res = {1'b0, a[DATA_W-1:1]};
        r.c   = a[0];
      end
      OP_MOV: r.res = a;
      OP_LDI: r.res = imm;
`ifdef RF_ALU_MUL_EN
      OP_MUL: begin
        p     = a * b;
        r.res = p[DATA_W-1:0];
        r.c   = |p[2*DATA_W-1:DATA_W];
      end
`endif
      default: r.ok = 1'b0;
    endcase
    r.z = (r.res == '0);
    return r;
  endfunction

  state_t             state_q, state_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0]  result_q, result_d;
  logic               z_q, z_d;
  logic               c_q, c_d;
  logic               v_q, v_d;

  logic [3:0]         op;
  logic [ADDR_W-1:0]  rd;
  alu_t               alu;

  assign op  = instr_q[15:12];
  assign rd  = instr_q[11:8];
  assign alu = alu_exec(op, rf_out1, rf_out2, instr_q[7:0]);

  assign flag_z = z_q;
  assign flag_c = c_q;
  assign flag_v = v_q;

  // State, latched instruction, result and flags; synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      instr_q  <= '0;
      result_q <= '0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      result_q <= result_d;
      z_q      <= z_d;
      c_q      <= c_d;
      v_q      <= v_d;
    end
  end

  // Next-state and outputs; every strobe is forced low while reset is held
  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    result_d      = result_q;
    z_d           = z_q;
    c_d           = c_q;
    v_d           = v_q;
    instr_ready   = 1'b0;
    rf_r_address1 = '0;
    rf_r_address2 = '0;
    rf_w_address  = '0;
    rf_data       = '0;
    rf_write_en   = 1'b0;
    done          = 1'b0;
    illegal       = 1'b0;
    case (state_q)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          instr_d = instr;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        rf_r_address1 = instr_q[7:4];
        rf_r_address2 = instr_q[3:0];
        if (alu.ok) begin
          result_d = alu.res;
          z_d      = alu.z;
          c_d      = alu.c;
          v_d      = alu.v;
        end
        state_d = S_WB;
      end
      S_WB: begin
        done    = 1'b1;
        illegal = !alu.ok;
        if (alu.ok && (op != OP_CMP)) begin
          rf_write_en  = 1'b1;
          rf_w_address = rd;
          rf_data      = result_q;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (!rst_n) begin
      instr_ready  = 1'b0;
      done         = 1'b0;
      illegal      = 1'b0;
      rf_write_en  = 1'b0;
      rf_w_address = '0;
      rf_data      = '0;
    end
  end

endmodule

// File: tb/tb_rf_alu_sequencer.sv
// Scoreboard bench for rf_alu_sequencer with a behavioural register file.
module tb_rf_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic [3:0]  rf_r_address1, rf_r_address2, rf_w_address;
  logic [7:0]  rf_out1, rf_out2, rf_data;
  logic        rf_write_en, done, illegal, flag_z, flag_c, flag_v;

  rf_alu_sequencer dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .rf_r_address1(rf_r_address1),
    .rf_r_address2(rf_r_address2), .rf_out1(rf_out1), .rf_out2(rf_out2),
    .rf_w_address(rf_w_address), .rf_data(rf_data), .rf_write_en(rf_write_en),
    .done(done), .illegal(illegal), .flag_z(flag_z), .flag_c(flag_c),
    .flag_v(flag_v)
  );

  always #5 clk = ~clk;

  logic [7:0] rf [16];
  assign rf_out1 = rf[rf_r_address1];
  assign rf_out2 = rf[rf_r_address2];
  always @(posedge clk) if (rf_write_en) rf[rf_w_address] <= rf_data;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       we;
    logic [3:0] wa;
    logic [7:0] wd;
    logic       z, c, v, ill;
    int         dcyc;
  } exp_t;

  exp_t sb[$];
  int   hs_cyc[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t ew(input logic [3:0] wa, input logic [7:0] wd,
                              input logic z, input logic c, input logic v);
    exp_t e;
    e.we = 1'b1; e.wa = wa; e.wd = wd; e.z = z; e.c = c; e.v = v; e.ill = 1'b0; e.dcyc = 0;
    return e;
  endfunction

  function automatic exp_t en(input logic z, input logic c, input logic v, input logic ill);
    exp_t e;
    e.we = 1'b0; e.wa = 4'h0; e.wd = 8'h00; e.z = z; e.c = c; e.v = v; e.ill = ill; e.dcyc = 0;
    return e;
  endfunction

  // Monitor: compare every completion against the head of the scoreboard
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_latency", cyc, e.dcyc);
        chk("write_en", rf_write_en, e.we);
        chk("w_address", rf_w_address, e.wa);
        chk("w_data", rf_data, e.wd);
        chk("illegal", illegal, e.ill);
        chk("flag_z", flag_z, e.z);
        chk("flag_c", flag_c, e.c);
        chk("flag_v", flag_v, e.v);
      end
    end else if (rf_write_en || illegal) begin
      chk("strobe_without_done", {rf_write_en, illegal}, 32'd0);
    end
  end

  // Offer one instruction; junk (LDI r1,0) is shown whenever the block is busy
  task automatic issue(input logic [15:0] ins, input exp_t e, input bit hold);
    int n = 0;
    forever begin
      @(negedge clk);
      instr_valid = 1'b1;
      if (instr_ready) begin
        instr = ins;
        @(posedge clk);
        #1;
        e.dcyc = cyc + 1;
        sb.push_back(e);
        hs_cyc.push_back(cyc);
        instr = 16'h9100;
        if (!hold) instr_valid = 1'b0;
        return;
      end
      instr = 16'h9100;
      n++;
      if (n > 20) begin
        chk("ready_timeout", 32'd0, 32'd1);
        return;
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
  endtask

  logic zp, cp, vp;

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = 8'h00;
    rst_n = 1'b0;
    instr_valid = 1'b0;
    instr = 16'h0000;
    repeat (3) @(negedge clk);
    chk("rst_ready", instr_ready, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_we", rf_write_en, 1'b0);
    chk("rst_flags", {flag_z, flag_c, flag_v}, 3'b000);
    rst_n = 1'b1;
    #1;
    chk("ready_after_release", instr_ready, 1'b1);

    issue(16'h917F, ew(4'h1, 8'h7F, 0, 0, 0), 0);  // LDI r1,0x7F
    issue(16'h9201, ew(4'h2, 8'h01, 0, 0, 0), 0);  // LDI r2,0x01
    issue(16'h0312, ew(4'h3, 8'h80, 0, 0, 1), 0);  // ADD r3,r1,r2
    issue(16'h1421, ew(4'h4, 8'h82, 0, 1, 0), 0);  // SUB r4,r2,r1
    issue(16'hAF11, en(1, 0, 0, 0), 0);            // CMP r1,r1 (rd=15 ignored)
    issue(16'h9581, ew(4'h5, 8'h81, 0, 0, 0), 0);  // LDI r5,0x81
    issue(16'h9910, ew(4'h9, 8'h10, 0, 0, 0), 0);  // LDI r9,0x10
    issue(16'h9A20, ew(4'hA, 8'h20, 0, 0, 0), 0);  // LDI r10,0x20
    issue(16'h6650, ew(4'h6, 8'h02, 0, 1, 0), 0);  // SHL r6,r5
    issue(16'h7750, ew(4'h7, 8'h40, 0, 1, 0), 0);  // SHR r7,r5
`ifdef RF_ALU_MUL_EN
    issue(16'hB89A, ew(4'h8, 8'h00, 1, 1, 0), 0);  // MUL r8,r9,r10
    zp = 1'b1; cp = 1'b1; vp = 1'b0;
`else
    issue(16'hB89A, en(0, 1, 0, 1), 0);            // opcode 11 illegal
    zp = 1'b0; cp = 1'b1; vp = 1'b0;
`endif
    issue(16'hC100, en(zp, cp, vp, 1), 0);         // opcode 12 illegal
    issue(16'h0F44, ew(4'hF, 8'h04, 0, 1, 1), 0);  // ADD r15,r4,r4 carry+overflow
    issue(16'h1444, ew(4'h4, 8'h00, 1, 0, 0), 0);  // SUB r4,r4,r4 (rd=rs)
    drain();

    // Burst with valid held high; junk offered during EXEC/WB must be ignored
    hs_cyc.delete();
    issue(16'h2B12, ew(4'hB, 8'h01, 0, 0, 0), 1);  // AND r11,r1,r2
    issue(16'h3C12, ew(4'hC, 8'h7F, 0, 0, 0), 1);  // OR  r12,r1,r2
    issue(16'h4DB1, ew(4'hD, 8'h7E, 0, 0, 0), 1);  // XOR r13,r11,r1 (dependent)
    issue(16'h5E10, ew(4'hE, 8'h80, 0, 0, 0), 0);  // NOT r14,r1
    for (int i = 1; i < 4; i++) chk("burst_spacing", hs_cyc[i] - hs_cyc[i-1], 3);
    drain();
    chk("rf_r1_kept", rf[1], 8'h7F);
    chk("rf_r3", rf[3], 8'h80);
    chk("rf_r13", rf[13], 8'h7E);
    chk("rf_r0_untouched", rf[0], 8'h00);
    chk("rf_r15", rf[15], 8'h04);

    // Reset during WB of ADD r3,r1,r1 must abort the write
    @(negedge clk);
    chk("idle_before_abort", instr_ready, 1'b1);
    instr_valid = 1'b1;
    instr = 16'h0311;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_we", rf_write_en, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_ready", instr_ready, 1'b0);
    @(negedge clk);
    chk("abort_r3_kept", rf[3], 8'h80);
    chk("abort_flags_cleared", {flag_z, flag_c, flag_v}, 3'b000);
    rst_n = 1'b1;
    #1;
    chk("abort_ready_after_release", instr_ready, 1'b1);
    issue(16'h8210, ew(4'h2, 8'h7F, 0, 0, 0), 0);  // MOV r2,r1
    drain();
    chk("rf_r2_mov", rf[2], 8'h7F);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
